// File: rtl/mem_io_responder_if.sv
// CPU-side byte bus between the core (master) and the memory/IO responder (slave).
interface mem_io_responder_if;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic [7:0]  mem_din;
  logic        io_buffer_full;

  modport master (
    output mem_a, mem_dout, mem_wr,
    input  mem_din, io_buffer_full
  );

  modport slave (
    input  mem_a, mem_dout, mem_wr,
    output mem_din, io_buffer_full
  );
endinterface

// File: rtl/mem_io_responder.sv
// Memory-and-IO responder for the CPU byte bus.
// RAM below the IO window, IO window at mem_a[17:16]==2'b11 holding the UART
// TX FIFO (0x30000 write), RX byte port (0x30000 read), cycle-counter snapshot
// (0x30004..7 read) and the sticky program-stop flag (0x30004 write).
// Optional build macro MEM_IO_STOP_LOCK_EN: once stop is set, all further
// bus writes are ignored; reads and TX draining keep working.
module mem_io_responder #(
  parameter int ADDR_W   = 17,
  parameter int TX_DEPTH = 8
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic               rdy_in,
  mem_io_responder_if.slave  bus,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic               rx_pop,
  output logic               stop
);

  localparam int PTR_W = $clog2(TX_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [7:0]        ram [0:(1 << ADDR_W) - 1];
  logic [7:0]        fifo [0:TX_DEPTH - 1];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;
  logic [31:0]       cyc;
  logic [31:0]       snap;
  logic [7:0]        din_q;

  logic              is_io;
  logic [ADDR_W-1:0] ram_idx;
  logic [2:0]        io_off;
  logic              wr_lock;
  logic              bus_wr;
  logic              bus_rd;
  logic              push_req;
  logic [7:0]        push_byte;
  logic              push_ok;
  logic              pop;
  logic              unused_addr;

  assign is_io       = (bus.mem_a[17:16] == 2'b11);
  assign ram_idx     = bus.mem_a[ADDR_W-1:0];
  assign io_off      = bus.mem_a[2:0];
  assign unused_addr = ^bus.mem_a[31:18];

`ifdef MEM_IO_STOP_LOCK_EN
  assign wr_lock = stop;
`else
  assign wr_lock = 1'b0;
`endif

  assign bus_wr = rdy_in && bus.mem_wr && !wr_lock;
  assign bus_rd = rdy_in && !bus.mem_wr;

  // Decode FIFO pushes: data port filters zero bytes, the stop port forces a 0x00 marker.
  always_comb begin
    push_req  = 1'b0;
    push_byte = bus.mem_dout;
    if (bus_wr && is_io) begin
      if (io_off == 3'd0) begin
        push_req = (bus.mem_dout != 8'h00);
      end else if (io_off == 3'd4) begin
        push_req  = 1'b1;
        push_byte = 8'h00;
      end
    end
  end

  // A full FIFO drops the push even if the head leaves in the same cycle.
  assign push_ok            = push_req && (count != CNT_W'(TX_DEPTH));
  assign tx_valid           = (count != '0);
  assign pop                = tx_valid && tx_ready;
  assign tx_data            = tx_valid ? fifo[head] : 8'h00;
  assign bus.io_buffer_full = (count >= CNT_W'(TX_DEPTH - 1));
  assign bus.mem_din        = din_q;

  // RAM write port; contents intentionally survive reset.
  always_ff @(posedge clk_in) begin
    if (bus_wr && !is_io) ram[ram_idx] <= bus.mem_dout;
  end

  // FIFO storage; stale entries are masked by tx_valid so no reset is needed.
  always_ff @(posedge clk_in) begin
    if (push_ok) fifo[tail] <= push_byte;
  end

  // FIFO pointers and occupancy; draining is independent of rdy_in.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push_ok) tail <= tail + PTR_W'(1);
      if (pop)     head <= head + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Free-running cycle counter and sticky stop flag.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cyc  <= '0;
      stop <= 1'b0;
    end else begin
      cyc <= cyc + 32'd1;
      if (bus_wr && is_io && (io_off == 3'd4)) stop <= 1'b1;
    end
  end

  // Registered read path; mem_din holds on writes and paused cycles.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      din_q  <= 8'h00;
      rx_pop <= 1'b0;
      snap   <= '0;
    end else begin
      rx_pop <= 1'b0;
      if (bus_rd) begin
        if (!is_io) begin
          din_q <= ram[ram_idx];
        end else begin
          case (io_off)
            3'd0: begin
              din_q  <= rx_valid ? rx_data : 8'h00;
              rx_pop <= rx_valid;
            end
            3'd4: begin
              snap  <= cyc;
              din_q <= cyc[7:0];
            end
            3'd5:    din_q <= snap[15:8];
            3'd6:    din_q <= snap[23:16];
            3'd7:    din_q <= snap[31:24];
            default: din_q <= 8'h00;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_io_responder.sv
// Scoreboard bench for mem_io_responder: driver updates a queue/array model and
// pushes expectations; an independent monitor compares DUT outputs.
module tb_mem_io_responder;
  localparam int DEPTH = 8;
  localparam int AW    = 17;
`ifdef MEM_IO_STOP_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic       clk_in   = 1'b0;
  logic       rst_n_in = 1'b1;
  logic       rdy_in   = 1'b0;
  logic       tx_ready = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data  = 8'h00;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       rx_pop;
  logic       stop;

  mem_io_responder_if bus ();

  mem_io_responder #(.ADDR_W(AW), .TX_DEPTH(DEPTH)) dut (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .rdy_in   (rdy_in),
    .bus      (bus),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_pop   (rx_pop),
    .stop     (stop)
  );

  always #5 clk_in = ~clk_in;

  // reference model state
  logic [7:0]  mram [int];
  logic [7:0]  din_q [$];
  logic [7:0]  tx_q [$];
  int          model_cnt   = 0;
  logic        model_stop  = 1'b0;
  logic [31:0] model_cyc   = 0;
  logic [31:0] snap_m      = 0;
  logic        model_rx_pop = 1'b0;
  logic        cur_txr     = 1'b0;

  int tests = 0;
  int fails = 0;

  logic [31:0] addr_tab [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One bus cycle: drive at the falling edge and advance the model to the next rising edge.
  task automatic step(input logic rdy, input logic wr, input logic [31:0] a, input logic [7:0] d,
                      input logic txr, input logic rxv, input logic [7:0] rxd);
    logic io, pop, push, wr_ok;
    logic [2:0] off;
    logic [7:0] pb, v;
    int idx;
    @(negedge clk_in);
    rdy_in = rdy; bus.mem_wr = wr; bus.mem_a = a; bus.mem_dout = d;
    tx_ready = txr; rx_valid = rxv; rx_data = rxd;
    io  = (a[17:16] == 2'b11);
    off = a[2:0];
    idx = int'(a[AW-1:0]);
    pop = (model_cnt != 0) && txr;
    push = 1'b0; pb = d; model_rx_pop = 1'b0;
    wr_ok = rdy && wr && !(LOCK && model_stop);
    if (wr_ok) begin
      if (!io) mram[idx] = d;
      else if (off == 3'd0) push = (d != 8'h00);
      else if (off == 3'd4) begin model_stop = 1'b1; push = 1'b1; pb = 8'h00; end
    end
    if (rdy && !wr) begin
      v = 8'h00;
      if (!io) v = mram.exists(idx) ? mram[idx] : 8'h00;
      else case (off)
        3'd0: begin v = rxv ? rxd : 8'h00; model_rx_pop = rxv; end
        3'd4: begin snap_m = model_cyc; v = snap_m[7:0]; end
        3'd5: v = snap_m[15:8];
        3'd6: v = snap_m[23:16];
        3'd7: v = snap_m[31:24];
        default: v = 8'h00;
      endcase
      din_q.push_back(v);
    end
    if (push && model_cnt < DEPTH) begin tx_q.push_back(pb); model_cnt++; end
    if (pop) model_cnt--;
    model_cyc++;
  endtask

  task automatic wr_mem(input logic [31:0] a, input logic [7:0] d);
    step(1'b1, 1'b1, a, d, cur_txr, 1'b0, 8'h00);
  endtask

  task automatic rd_mem(input logic [31:0] a);
    step(1'b1, 1'b0, a, 8'h00, cur_txr, 1'b0, 8'h00);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 8'h00, cur_txr, 1'b0, 8'h00);
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    rst_n_in = 1'b0; rdy_in = 1'b0; bus.mem_wr = 1'b0; tx_ready = 1'b0; rx_valid = 1'b0;
    #1;
    chk("rst_stop", stop, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_rx_pop", rx_pop, 0);
    chk("rst_io_full", bus.io_buffer_full, 0);
    chk("rst_mem_din", bus.mem_din, 0);
    model_cnt = 0; tx_q.delete(); din_q.delete();
    model_stop = 1'b0; snap_m = 0; model_rx_pop = 1'b0;
    @(negedge clk_in);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    model_cyc = 1;
  endtask

  // monitor
  logic [7:0] last_din = 8'h00;
  logic       samp_rd;
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk_in); #2;
      samp_rd = rst_n_in && rdy_in && !bus.mem_wr;
      if (rst_n_in && tx_valid && tx_ready) begin
        if (tx_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL tx_unexpected: got byte %0h, none expected", tx_data);
        end else begin
          e = tx_q.pop_front();
          chk("tx_data", tx_data, e);
        end
      end
      @(posedge clk_in); #1;
      if (!rst_n_in) begin
        last_din = 8'h00;
      end else begin
        if (samp_rd) begin
          if (din_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL din_missing: read seen with no expectation queued");
          end else last_din = din_q.pop_front();
        end
        chk("mem_din", bus.mem_din, last_din);
        chk("tx_valid", tx_valid, model_cnt != 0);
        chk("io_buffer_full", bus.io_buffer_full, model_cnt >= DEPTH - 1);
        chk("stop", stop, model_stop);
        chk("rx_pop", rx_pop, model_rx_pop);
      end
    end
  end

  initial begin
    int r;
    logic [31:0] a, hi;
    logic [7:0] d;
    bus.mem_a = 0; bus.mem_dout = 0; bus.mem_wr = 0;
    for (int i = 0; i < 16; i++) addr_tab[i] = (i * 32'h2345 + 32'd7) & 32'h1FFFF;
    addr_tab[0] = 32'h0; addr_tab[1] = 32'h10; addr_tab[2] = 32'h20; addr_tab[3] = 32'h1FFFF;

    do_reset();
    wr_mem(32'h1FFFF, 8'h3C);
    do_reset();
    rd_mem(32'h1FFFF);
    wr_mem(32'h10, 8'hA5);
    rd_mem(32'h10);
    idle(1);
    for (int i = 2; i < 16; i++) wr_mem(addr_tab[i], 8'($urandom));
    wr_mem(32'h20, 8'h55);

    // TX fill, filter, overflow, drain
    cur_txr = 1'b0;
    wr_mem(32'h30000, "H"); wr_mem(32'h30000, "i"); wr_mem(32'h30000, 8'h00);
    for (int i = 0; i < 6; i++) wr_mem(32'h30000, 8'h61 + 8'(i));
    wr_mem(32'h30000, "X");
    step(1'b1, 1'b1, 32'h30000, "Y", 1'b1, 1'b0, 8'h00);
    cur_txr = 1'b1;
    idle(12);

    // pause: no bus action, FIFO drains
    cur_txr = 1'b0;
    wr_mem(32'h30000, "P"); wr_mem(32'h30000, "Q");
    step(1'b0, 1'b1, 32'h30000, "R", 1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 32'h10, 8'h99, 1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b0, 32'h1FFFF, 8'h00, 1'b1, 1'b0, 8'h00);
    rd_mem(32'h10);
    cur_txr = 1'b1;
    idle(3);

    // RX port
    step(1'b1, 1'b0, 32'h30000, 8'h00, 1'b1, 1'b1, 8'h41);
    idle(2);
    step(1'b1, 1'b0, 32'h30000, 8'h00, 1'b1, 1'b0, 8'h41);
    idle(2);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      r  = $urandom_range(0, 9);
      hi = $urandom & 32'hFFFC0000;
      d  = 8'($urandom);
      a  = addr_tab[$urandom_range(0, 15)] | hi;
      case (r)
        0, 1: step($urandom_range(0, 6) != 0, 1'b1, a, d, 1'($urandom), 1'b0, 8'h00);
        2, 3: step($urandom_range(0, 6) != 0, 1'b0, a, d, 1'($urandom), 1'b0, 8'h00);
        4:    step($urandom_range(0, 6) != 0, 1'b1, 32'h30000 | hi,
                   ($urandom_range(0, 3) == 0) ? 8'h00 : d, 1'($urandom), 1'b0, 8'h00);
        5:    step(1'b1, 1'b0, 32'h30000 | hi, d, 1'($urandom), 1'($urandom), 8'($urandom));
        6:    step(1'b1, 1'b0, 32'h30004 + 32'($urandom_range(0, 3)), d, 1'($urandom), 1'b0, 8'h00);
        7: begin
          a = 32'h30000 | hi | 32'($urandom_range(5, 7));
          if ($urandom_range(0, 1) == 0) a = (a & ~32'h7) | 32'($urandom_range(1, 3));
          step(1'b1, 1'($urandom), a, d, 1'($urandom), 1'b0, 8'h00);
        end
        default: step(1'b0, 1'b0, 32'h0, 8'h00, 1'($urandom), 1'b0, 8'h00);
      endcase
    end

    // cycle counter snapshot at 300 cycles after reset
    cur_txr = 1'b0;
    do_reset();
    idle(299);
    rd_mem(32'h30004); rd_mem(32'h30005); rd_mem(32'h30006); rd_mem(32'h30007);
    idle(1);

    // stop flag, lock behaviour, async reset
    wr_mem(32'h30004, 8'h12);
    wr_mem(32'h30000, "Z");
    wr_mem(32'h20, 8'h77);
    rd_mem(32'h20);
    cur_txr = 1'b1;
    idle(3);
    cur_txr = 1'b0;
    wr_mem(32'h30000, "W");
    idle(1);
    do_reset();
    idle(3);

    tests++;
    if (din_q.size() != 0) begin
      fails++;
      $display("FAIL din_leftover: got %0d pending reads, expected 0", din_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_io_responder.md
# mem_io_responder

Memory-and-I/O responder on the far end of the CPU's byte-wide memory bus. It answers the `mem_a`/`mem_dout`/`mem_wr` requests the CPU core issues and returns `mem_din` one cycle later. It decodes the I/O window at `mem_a[17:16]==2'b11`, which carries a UART transmit FIFO, a receive byte port, a cycle counter and a program-stop flag, and it drives the core's `io_buffer_full`.

## Interface
- `ADDR_W`, default 17: RAM byte-address bits; RAM size is 2^ADDR_W bytes.
- `TX_DEPTH`, default 8: TX FIFO entries; power of two, ≥4.

Ports:
- `clk_in`  in  1  system clock
- `rst_n_in`  in  1  reset, asynchronous, active-low
- `rdy_in`  in  1  bus-cycle enable; low = CPU paused
- `mem_a`  in  32  byte address from CPU
- `mem_dout`  in  8  write data from CPU
- `mem_wr`  in  1  1 = write, 0 = read
- `mem_din`  out  8  read data to CPU (registered)
- `io_buffer_full`  out  1  TX FIFO nearly full
- `tx_data`  out  8  FIFO head byte
- `tx_valid`  out  1  FIFO non-empty
- `tx_ready`  in  1  UART sink accepts head
- `rx_data`  in  8  received byte
- `rx_valid`  in  1  `rx_data` holds an unread byte
- `rx_pop`  out  1  one-cycle consume strobe for `rx_data`
- `stop`  out  1  sticky program-stop flag

## Operation
- **Region decode.** RAM when `mem_a[17:16]!=2'b11`, indexed by `mem_a[ADDR_W-1:0]`. IO otherwise, offset `mem_a[2:0]`.
- **Bus actions.** All bus actions happen only on edges where `rdy_in=1`.
- **RAM write.** Stores `mem_dout`.
- **RAM read.** `mem_din <= ram[idx]`.
- **IO write, 0x30000.**
  - If `mem_dout!=0` and count<TX_DEPTH: push the byte.
  - A zero byte is ignored.
  - A push when full is dropped.
- **IO write, 0x30004.**
  - Sets `stop`.
  - Pushes 0x00 if not full; this push bypasses the zero filter.
- **IO read, 0x30000.** `mem_din <= rx_valid ? rx_data : 8'h00`. `rx_pop` pulses in the following cycle when `rx_valid` was 1.
- **IO read, 0x30004.** Snapshot register `<= cycle counter`; `mem_din <=` counter[7:0].
- **IO read, 0x30005/6/7.** Return snapshot bytes 1/2/3. The snapshot is not updated by these reads.
- **Other IO offsets.** Reads return 0x00; writes are ignored.
- **Cycle counter.** 32-bit, increments every `clk_in` edge after reset regardless of `rdy_in`; wraps from 0xFFFFFFFF to 0.
- **TX FIFO.**
  - Circular buffer with head/tail pointers and a count of log2(TX_DEPTH)+1 bits.
  - `tx_valid` = count!=0; `tx_data` = entry at head.
  - Pop on `tx_valid && tx_ready`.
  - Draining continues while `rdy_in=0`.
  - Simultaneous push and pop: both take effect and count is unchanged. When count==TX_DEPTH the push is dropped even with a pop in the same cycle.
- **`io_buffer_full`.** Combinational from the count register: count ≥ TX_DEPTH-1. This gives one entry of margin for the CPU's one-cycle write pipeline.

## Timing
- **Reset values.**
  - `mem_din`=0, `tx_valid`=0, `tx_data`=0, `rx_pop`=0, `stop`=0, `io_buffer_full`=0.
  - Counter=0, snapshot=0, pointers and count=0.
  - RAM contents are not reset.
- **Reset mid-operation.** Reset asserted mid-operation clears the FIFO immediately (async); in-flight reads are lost.
- **Read latency.** Address presented before edge N → `mem_din` valid after edge N, held until the next read edge.
- **Pause.** `mem_din` holds while `rdy_in=0`, and on write cycles.
- **Read-after-write.** A write at edge N followed by a read of the same address at edge N+1 returns the new data.
- **Push visibility.** A push at edge N makes `tx_valid` high after edge N. `io_buffer_full` updates after the same edge.
- **`rx_pop`.** Registered, exactly one cycle wide, one pulse per qualifying read.

## Configuration
- `MEM_IO_STOP_LOCK_EN`
  - **Defined:** once `stop`=1, all subsequent RAM writes and IO writes are ignored. Reads and TX drain continue.
  - **Undefined:** writes after `stop` behave normally; `stop` stays sticky.

## Test plan
- Write 0xA5 to 0x00010, then read 0x00010 on the next cycle → `mem_din`=0xA5 one cycle later. Read 0x1FFFF after reset (with RAM preloaded 0x3C) → 0x3C.
- With `tx_ready`=0, write 'H','i',0x00 to 0x30000 → count=2, zero ignored. Fill to TX_DEPTH-1 → `io_buffer_full`=1. A write with count==TX_DEPTH → dropped. Raise `tx_ready` → bytes emerge in order 'H','i',….
- Hold `rdy_in`=0 while issuing a write to 0x30000 and a RAM write → no push, RAM unchanged, counter still increments, FIFO still drains.
- After 300 cycles from reset, read 0x30004..0x30007 on four consecutive cycles → bytes form 300 (±latch cycle exactly equal to counter at the 0x30004 edge), e.g. 0x2C,0x01,0x00,0x00.
- With `rx_valid`=1 and `rx_data`=0x41, read 0x30000 → `mem_din`=0x41 and `rx_pop` high for one cycle. With `rx_valid`=0 → `mem_din`=0x00 and no pulse.
- Write 0x30004 → `stop`=1 and 0x00 queued on `tx_data`. With `MEM_IO_STOP_LOCK_EN`, a following RAM write of 0x77 to 0x20 leaves the old value. Assert `rst_n_in` low → `stop`=0 and `tx_valid`=0 immediately.
